// File: rtl/cook_sequencer_if.sv
// cook_if: front-panel inputs and timer-control outputs of the cook sequencer
interface cook_if;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] bcd;
    logic       loadn;
    logic       timer_clrn;
    logic       tick;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;
    modport master(output keypad, startn, stopn, door_closed, timer_zero,
                   input bcd, loadn, timer_clrn, tick, mag_on, beep, state);
    modport slave(input keypad, startn, stopn, door_closed, timer_zero,
                  output bcd, loadn, timer_clrn, tick, mag_on, beep, state);
endinterface

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave controller sequencing digit entry, cook countdown ticks and end beep
module cook_sequencer #(
    parameter int CLK_DIV    = 100,
    parameter int MAX_DIGITS = 3,
    parameter int BEEP_TICKS = 3
) (
    input logic   clock,
    input logic   clearn,
    cook_if.slave io
);
    typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, COOKING = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [DW-1:0] DMAX  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] MAXD  = CW'(MAX_DIGITS);
    localparam logic [BW-1:0] BLAST = BW'(BEEP_TICKS - 1);
    state_t        st;
    logic [9:0]    key_q, key_p;
    logic          start_q, start_p, stop_q, stop_p;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic [3:0]    bcd_r, key_idx;
    logic          loadn_r, clrn_r, beep_r;
    logic          key_ev, key_ok, start_ev, stop_ev, start_ok, div_wrap;
    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 10; i++) if (key_q[i]) key_idx = 4'(i);
    end
    assign key_ev   = (|key_q) && !(|key_p);
    assign key_ok   = key_ev && $onehot(key_q);
    assign start_ev = start_p && !start_q;
    assign stop_ev  = stop_p && !stop_q;
    assign start_ok = start_ev && io.door_closed && !io.timer_zero;
    assign div_wrap = div == DMAX;
    assign io.state      = st;
    assign io.bcd        = bcd_r;
    assign io.loadn      = loadn_r;
    assign io.timer_clrn = clrn_r;
    assign io.beep       = beep_r;
    assign io.mag_on     = st == COOKING && io.door_closed;
    // a cycle that leaves COOKING never counts the timer
    assign io.tick = st == COOKING && div_wrap && io.door_closed && !stop_ev && !io.timer_zero;
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            st      <= IDLE;
            key_q   <= '0;
            key_p   <= '0;
            start_q <= 1'b1;
            start_p <= 1'b1;
            stop_q  <= 1'b1;
            stop_p  <= 1'b1;
            div     <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            bcd_r   <= '0;
            loadn_r <= 1'b1;
            clrn_r  <= 1'b1;
            beep_r  <= 1'b0;
        end else begin
            key_q   <= io.keypad;
            key_p   <= key_q;
            start_q <= io.startn;
            start_p <= start_q;
            stop_q  <= io.stopn;
            stop_p  <= stop_q;
            loadn_r <= 1'b1;
            clrn_r  <= 1'b1;
            beep_r  <= 1'b0;
            case (st)
                IDLE, ENTRY: begin
                    if (st == ENTRY && stop_ev) begin
                        st     <= IDLE;
                        clrn_r <= 1'b0;
                        cnt    <= '0;
                    end else if (st == ENTRY && start_ok) begin
                        st  <= COOKING;
                        div <= '0;
                    end else if (key_ok && cnt < MAXD) begin
                        st      <= ENTRY;
                        bcd_r   <= key_idx;
                        loadn_r <= 1'b0;
                        cnt     <= cnt + 1'b1;
                    end
                end
                COOKING: begin
                    if (io.timer_zero) begin
                        st     <= DONE;
                        div    <= '0;
                        bcnt   <= '0;
                        beep_r <= 1'b1;
                    end else if (!io.door_closed || stop_ev) st <= PAUSED;
                    else div <= div_wrap ? '0 : div + 1'b1;
                end
                PAUSED: begin
                    if (stop_ev) begin
                        st     <= IDLE;
                        clrn_r <= 1'b0;
                        cnt    <= '0;
                    end else if (start_ok) st <= COOKING;
                end
                DONE: begin
                    if (stop_ev || key_ev || (div_wrap && bcnt == BLAST)) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else begin
                        beep_r <= 1'b1;
                        div    <= div_wrap ? '0 : div + 1'b1;
                        if (div_wrap) bcnt <= bcnt + 1'b1;
                    end
                end
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: directed and random stimulus checked against a cycle-level behavioural model
module tb_cook_sequencer;
    localparam int CLK_DIV = 4, MAX_DIGITS = 3, BEEP_TICKS = 3;
    logic clock = 1'b0;
    logic clearn = 1'b0;
    cook_if bus();
    cook_sequencer #(.CLK_DIV(CLK_DIV), .MAX_DIGITS(MAX_DIGITS), .BEEP_TICKS(BEEP_TICKS)) dut (
        .clock(clock), .clearn(clearn), .io(bus));
    always #5 clock = ~clock;
    int errors = 0, checks = 0;
    int m_state, m_div, m_cnt, m_beeps, m_bcd;
    bit m_loadn, m_clrn;
    logic [9:0] r_key, p_key;
    bit r_start, p_start, r_stop, p_stop;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_div = 0; m_cnt = 0; m_beeps = 0; m_bcd = 0;
        m_loadn = 1; m_clrn = 1;
        r_key = '0; p_key = '0;
        r_start = 1; p_start = 1; r_stop = 1; p_stop = 1;
    endtask

    // state numbers: 0 idle, 1 entry, 2 cooking, 3 paused, 4 done
    task automatic model_step();
        bit kev, sev, pev, go;
        kev = r_key != 0 && p_key == 0;
        sev = p_start && !r_start;
        pev = p_stop && !r_stop;
        go = sev && bus.door_closed && !bus.timer_zero;
        m_loadn = 1; m_clrn = 1;
        case (m_state)
            0, 1: begin
                if (m_state == 1 && pev) begin
                    m_state = 0; m_clrn = 0; m_cnt = 0;
                end else if (m_state == 1 && go) begin
                    m_state = 2; m_div = 0;
                end else if (kev && $countones(r_key) == 1 && m_cnt < MAX_DIGITS) begin
                    for (int i = 0; i < 10; i++) if (r_key[i]) m_bcd = i;
                    m_loadn = 0; m_cnt++; m_state = 1;
                end
            end
            2: begin
                if (bus.timer_zero) begin
                    m_state = 4; m_div = 0; m_beeps = 0;
                end else if (!bus.door_closed || pev) m_state = 3;
                else m_div = (m_div + 1) % CLK_DIV;
            end
            3: begin
                if (pev) begin
                    m_state = 0; m_clrn = 0; m_cnt = 0;
                end else if (go) m_state = 2;
            end
            default: begin
                if (pev || kev) begin
                    m_state = 0; m_cnt = 0;
                end else begin
                    if (m_div == CLK_DIV - 1) m_beeps++;
                    m_div = (m_div + 1) % CLK_DIV;
                    if (m_beeps == BEEP_TICKS) begin
                        m_state = 0; m_cnt = 0;
                    end
                end
            end
        endcase
        p_key = r_key; r_key = bus.keypad;
        p_start = r_start; r_start = bus.startn;
        p_stop = r_stop; r_stop = bus.stopn;
    endtask

    function automatic bit exp_tick();
        return m_state == 2 && m_div == CLK_DIV - 1 && bus.door_closed && !(p_stop && !r_stop) && !bus.timer_zero;
    endfunction

    task automatic compare_all();
        check("state", int'(bus.state), m_state);
        check("bcd", int'(bus.bcd), m_bcd);
        check("loadn", int'(bus.loadn), int'(m_loadn));
        check("timer_clrn", int'(bus.timer_clrn), int'(m_clrn));
        check("beep", int'(bus.beep), int'(m_state == 4));
        check("mag_on", int'(bus.mag_on), int'(m_state == 2 && bus.door_closed));
        check("tick", int'(bus.tick), int'(exp_tick()));
    endtask

    task automatic cyc(input logic [9:0] k, input bit st, input bit sp, input bit dr, input bit tz);
        @(posedge clock);
        model_step();
        #1;
        bus.keypad = k; bus.startn = st; bus.stopn = sp; bus.door_closed = dr; bus.timer_zero = tz;
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) cyc(10'd0, 1, 1, 1, 0);
    endtask

    task automatic press(input logic [9:0] k);
        cyc(k, 1, 1, 1, 0);
        idle_cyc(2);
    endtask

    task automatic start_cook();
        cyc(10'd0, 0, 1, 1, 0);
        idle_cyc(2);
    endtask

    initial begin
        int n, seen;
        bus.keypad = '0; bus.startn = 1; bus.stopn = 1; bus.door_closed = 1; bus.timer_zero = 0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        clearn = 1;
        press(10'd2); press(10'd8); press(10'd1);
        check("entry_state", int'(bus.state), 1);
        n = 0;
        cyc(10'd32, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            idle_cyc(1);
            if (!bus.loadn) n++;
        end
        check("fourth_digit_loads", n, 0);
        start_cook();
        check("cook_mag_on", int'(bus.mag_on), 1);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            idle_cyc(1);
            seen = int'(bus.tick);
        end
        check("tick_seen", seen, 1);
        idle_cyc(2);
        cyc(10'd0, 1, 1, 0, 0);
        check("door_mag_off", int'(bus.mag_on), 0);
        check("door_no_tick", int'(bus.tick), 0);
        idle_cyc(1);
        check("paused_state", int'(bus.state), 3);
        cyc(10'd0, 0, 1, 1, 0);
        idle_cyc(2);
        check("resume_no_tick", int'(bus.tick), 0);
        idle_cyc(1);
        check("resume_tick", int'(bus.tick), 1);
        cyc(10'd0, 1, 0, 1, 0);
        cyc(10'd0, 1, 1, 1, 1);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            idle_cyc(1);
            n += int'(bus.beep);
        end
        check("beep_cycles", n, CLK_DIV * BEEP_TICKS);
        check("done_to_idle", int'(bus.state), 0);
        press(10'd4);
        start_cook();
        cyc(10'd0, 1, 1, 0, 0);
        idle_cyc(1);
        check("paused_again", int'(bus.state), 3);
        cyc(10'd0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1);
            if (!bus.timer_clrn) n++;
        end
        check("clrn_pulses", n, 1);
        check("stop_beats_start", int'(bus.state), 0);
        cyc(10'b0000001010, 1, 1, 1, 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            idle_cyc(1);
            if (!bus.loadn) n++;
        end
        check("multi_key_loads", n, 0);
        check("multi_key_state", int'(bus.state), 0);
        press(10'd64);
        start_cook();
        idle_cyc(2);
        check("pre_reset_mag_on", int'(bus.mag_on), 1);
        @(posedge clock);
        #2 clearn = 0;
        #1;
        check("areset_mag_on", int'(bus.mag_on), 0);
        check("areset_tick", int'(bus.tick), 0);
        check("areset_state", int'(bus.state), 0);
        model_reset();
        @(negedge clock);
        clearn = 1;
        compare_all();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [9:0] k;
            r = int'($urandom_range(0, 9));
            k = r < 6 ? 10'd0 : r < 9 ? 10'(1 << $urandom_range(0, 9)) : 10'($urandom);
            cyc(k, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
                $urandom_range(0, 11) != 0, $urandom_range(0, 39) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
